shift_operand_sequencer: RTL and testbench

- Multi-cycle sequencer that computes the ARM data-processing second operand (val2) and shifter carry-out using one narrow shift stage iterated over several cycles.
- It replaces a full 32-bit barrel shifter where area matters.
- It sits between the ID stage (operand/control source) and the EXE-stage ALU operand mux, with a start/busy/done handshake.
- Semantics are full ARM: RRX, LSR/ASR #32 encodings and the shifter carry.

---
 rtl/shift_operand_sequencer.sv | 163 ++++++++++++++++
 tb/tb_shift_operand_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_sequencer.sv
// shift_operand_sequencer: computes the ARM data-processing second operand
// (val2) and the shifter carry-out. A narrow shift step of STEP_BITS
// positions is applied once per cycle, so no full barrel shifter is needed.
module shift_operand_sequencer #(
  parameter int STEP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        los,
  input  logic        imm,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] val2,
  output logic        carry_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_RRX = 3'd4;

  localparam logic [5:0] STEP_MAX = 6'(STEP_BITS);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] w;
  logic        c;
  logic [2:0]  op;
  logic        rrx_cin;

  logic        accept;
  logic [4:0]  amt;
  logic [31:0] ld_w;
  logic [5:0]  ld_cnt;
  logic [2:0]  ld_op;
  logic [5:0]  step_s;
  logic [32:0] step_res;

  // Apply up to STEP_BITS single-bit shifts; returns {carry, word}.
  // The carry is always the last bit shifted out (for ROR, the new bit 31).
  function automatic logic [32:0] shift_step(input logic [31:0] w_in,
                                             input logic        c_in,
                                             input logic [2:0]  op_in,
                                             input logic [5:0]  s,
                                             input logic        rrx_bit);
    logic [31:0]        x;
    logic signed [31:0] xs;
    logic               cy;
    x  = w_in;
    cy = c_in;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (6'(i) < s) begin
        case (op_in)
          OP_LSL: begin cy = x[31]; x = {x[30:0], 1'b0}; end
          OP_LSR: begin cy = x[0];  x = {1'b0, x[31:1]}; end
          OP_ASR: begin cy = x[0];  xs = $signed(x); xs = xs >>> 1; x = xs; end
          OP_ROR: begin cy = x[0];  x = {x[0], x[31:1]}; end
          default: begin cy = x[0]; x = {rrx_bit, x[31:1]}; end
        endcase
      end
    end
    return {cy, x};
  endfunction

  assign accept   = start && !flush && ((state == ST_IDLE) || (state == ST_DONE));
  assign amt      = shift_operand[11:7];
  assign busy     = (state == ST_RUN);
  assign step_s   = (cnt < STEP_MAX) ? cnt : STEP_MAX;
  assign step_res = shift_step(w, c, op, step_s, rrx_cin);

  // Decode the instruction operand field into working word, count and op.
  always_comb begin
    ld_w   = val_rm;
    ld_cnt = 6'd0;
    ld_op  = OP_LSL;
    if (los) begin
      ld_w = {20'b0, shift_operand};
    end else if (imm) begin
      ld_w   = {24'b0, shift_operand[7:0]};
      ld_cnt = {1'b0, shift_operand[11:8], 1'b0};
      ld_op  = OP_ROR;
    end else begin
      case (shift_operand[6:5])
        2'b00: begin ld_op = OP_LSL; ld_cnt = {1'b0, amt}; end
        2'b01: begin ld_op = OP_LSR; ld_cnt = (amt == 5'd0) ? 6'd32 : {1'b0, amt}; end
        2'b10: begin ld_op = OP_ASR; ld_cnt = (amt == 5'd0) ? 6'd32 : {1'b0, amt}; end
        default: begin
          if (amt == 5'd0) begin ld_op = OP_RRX; ld_cnt = 6'd1; end
          else             begin ld_op = OP_ROR; ld_cnt = {1'b0, amt}; end
        end
      endcase
    end
  end

  // Working datapath: load on accept, then one shift step per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      w       <= ld_w;
      c       <= carry_in;
      op      <= ld_op;
      rrx_cin <= carry_in;
    end else if ((state == ST_RUN) && (cnt != 6'd0)) begin
      c <= step_res[32];
      w <= step_res[31:0];
    end
  end

  // Sequencer control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 6'd0;
      done      <= 1'b0;
      val2      <= 32'd0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        cnt   <= 6'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_RUN;
              cnt   <= ld_cnt;
            end
          end
          ST_RUN: begin
            if (cnt == 6'd0) begin
              val2      <= w;
              carry_out <= c;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              cnt <= cnt - step_s;
            end
          end
          ST_DONE: begin
            if (start) begin
              state <= ST_RUN;
              cnt   <= ld_cnt;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Directed testbench for shift_operand_sequencer (STEP_BITS=1 and STEP_BITS=4).
module tb_shift_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] val_rm = 32'd0;
  logic [11:0] shift_operand = 12'd0;
  logic        los = 1'b0;
  logic        imm = 1'b0;
  logic        carry_in = 1'b0;

  logic        busy1, done1, cout1;
  logic [31:0] val2_1;
  logic        busy4, done4, cout4;
  logic [31:0] val2_4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_operand_sequencer #(.STEP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .val_rm(val_rm), .shift_operand(shift_operand), .los(los), .imm(imm),
    .carry_in(carry_in), .busy(busy1), .done(done1), .val2(val2_1),
    .carry_out(cout1)
  );

  shift_operand_sequencer #(.STEP_BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .val_rm(val_rm), .shift_operand(shift_operand), .los(los), .imm(imm),
    .carry_in(carry_in), .busy(busy4), .done(done4), .val2(val2_4),
    .carry_out(cout4)
  );

  // Drive one request through its accept edge, then scramble the inputs.
  task automatic issue(input logic [31:0] v, input logic [11:0] so,
                       input logic l, input logic i, input logic ci);
    val_rm = v; shift_operand = so; los = l; imm = i; carry_in = ci;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    val_rm = 32'hDEADBEEF; shift_operand = 12'hFFF; los = 1'b0; imm = 1'b0;
    carry_in = ~ci;
  endtask

  // Count edges after the accept edge until each DUT raises done (-1 = timeout).
  task automatic wait_done(output int lat1, output int lat4, output bit busy_ok);
    lat1 = -1; lat4 = -1; busy_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (lat1 < 0 && done1) lat1 = n;
      if (lat4 < 0 && done4) lat4 = n;
      if (lat1 < 0 && !busy1) busy_ok = 1'b0;
      if (lat1 >= 0 && lat4 >= 0) break;
    end
  endtask

  task automatic idle_gap();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done1); end
    checks++; if (val2_1 !== 32'd0) begin failures++; $display("FAIL reset_val2 got=%h exp=0", val2_1); end
    checks++; if (cout1 !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout1); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_los();
    int l1, l4; bit bok;
    issue(32'h0, 12'hABC, 1'b1, 1'b0, 1'b1);
    wait_done(l1, l4, bok);
    checks++; if (l1 !== 1) begin failures++; $display("FAIL los_latency got=%0d exp=1", l1); end
    checks++; if (val2_1 !== 32'h00000ABC) begin failures++; $display("FAIL los_val2 got=%h exp=00000abc", val2_1); end
    checks++; if (cout1 !== 1'b1) begin failures++; $display("FAIL los_cout got=%b exp=1", cout1); end
    @(posedge clk); #1;
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL los_done_pulse got=%b exp=0", done1); end
    idle_gap();
  endtask

  task automatic test_imm();
    int l1, l4; bit bok;
    issue(32'h0, 12'h4FF, 1'b0, 1'b1, 1'b0);
    wait_done(l1, l4, bok);
    checks++; if (l1 !== 9) begin failures++; $display("FAIL imm_latency1 got=%0d exp=9", l1); end
    checks++; if (l4 !== 3) begin failures++; $display("FAIL imm_latency4 got=%0d exp=3", l4); end
    checks++; if (val2_1 !== 32'hFF000000) begin failures++; $display("FAIL imm_val2 got=%h exp=ff000000", val2_1); end
    checks++; if (cout1 !== 1'b1) begin failures++; $display("FAIL imm_cout got=%b exp=1", cout1); end
    idle_gap();
  endtask

  task automatic test_lsl();
    int l1, l4; bit bok;
    issue(32'h8000000F, 12'h200, 1'b0, 1'b0, 1'b1);
    wait_done(l1, l4, bok);
    checks++; if (l1 !== 5) begin failures++; $display("FAIL lsl_latency1 got=%0d exp=5", l1); end
    checks++; if (l4 !== 2) begin failures++; $display("FAIL lsl_latency4 got=%0d exp=2", l4); end
    checks++; if (val2_1 !== 32'h000000F0) begin failures++; $display("FAIL lsl_val2_1 got=%h exp=000000f0", val2_1); end
    checks++; if (val2_4 !== 32'h000000F0) begin failures++; $display("FAIL lsl_val2_4 got=%h exp=000000f0", val2_4); end
    checks++; if (cout1 !== 1'b0) begin failures++; $display("FAIL lsl_cout1 got=%b exp=0", cout1); end
    checks++; if (cout4 !== 1'b0) begin failures++; $display("FAIL lsl_cout4 got=%b exp=0", cout4); end
    idle_gap();
  endtask

  task automatic test_asr();
    int l1, l4; bit bok;
    issue(32'h80000001, 12'h040, 1'b0, 1'b0, 1'b0);
    checks++; if (val2_1 !== 32'h000000F0) begin failures++; $display("FAIL asr_val2_hold got=%h exp=000000f0", val2_1); end
    wait_done(l1, l4, bok);
    checks++; if (l1 !== 33) begin failures++; $display("FAIL asr_latency1 got=%0d exp=33", l1); end
    checks++; if (l4 !== 9) begin failures++; $display("FAIL asr_latency4 got=%0d exp=9", l4); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL asr_busy got=%b exp=1", bok); end
    checks++; if (val2_1 !== 32'hFFFFFFFF) begin failures++; $display("FAIL asr_val2 got=%h exp=ffffffff", val2_1); end
    checks++; if (cout1 !== 1'b1) begin failures++; $display("FAIL asr_cout got=%b exp=1", cout1); end
    idle_gap();
  endtask

  task automatic test_rrx();
    int l1, l4; bit bok;
    issue(32'h00000003, 12'h060, 1'b0, 1'b0, 1'b1);
    wait_done(l1, l4, bok);
    checks++; if (l1 !== 2) begin failures++; $display("FAIL rrx_latency got=%0d exp=2", l1); end
    checks++; if (val2_1 !== 32'h80000001) begin failures++; $display("FAIL rrx_val2 got=%h exp=80000001", val2_1); end
    checks++; if (cout1 !== 1'b1) begin failures++; $display("FAIL rrx_cout got=%b exp=1", cout1); end
    idle_gap();
  endtask

  task automatic test_back_to_back();
    int l1, l4; bit bok;
    issue(32'h12345678, 12'h460, 1'b0, 1'b0, 1'b1);
    wait_done(l1, l4, bok);
    checks++; if (l1 !== 9) begin failures++; $display("FAIL ror_latency got=%0d exp=9", l1); end
    checks++; if (val2_1 !== 32'h78123456) begin failures++; $display("FAIL ror_val2 got=%h exp=78123456", val2_1); end
    checks++; if (cout1 !== 1'b0) begin failures++; $display("FAIL ror_cout got=%b exp=0", cout1); end
    // dut1 is in DONE now; a new start must begin RUN on this edge.
    issue(32'h8000000F, 12'h200, 1'b0, 1'b0, 1'b1);
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL b2b_done_clear got=%b exp=0", done1); end
    l1 = -1;
    for (int n = 1; n <= 60; n++) begin
      start = (n == 2);
      if (n == 2) begin los = 1'b1; shift_operand = 12'h123; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done1) begin l1 = n; break; end
    end
    checks++; if (l1 !== 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", l1); end
    checks++; if (val2_1 !== 32'h000000F0) begin failures++; $display("FAIL b2b_val2 got=%h exp=000000f0", val2_1); end
    checks++; if (cout1 !== 1'b0) begin failures++; $display("FAIL b2b_cout got=%b exp=0", cout1); end
    idle_gap();
  endtask

  task automatic test_flush();
    bit seen;
    issue(32'h80000001, 12'h040, 1'b0, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%b exp=1", busy1); end
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy1); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done1 || busy1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b exp=0", seen); end
    checks++; if (val2_1 !== 32'h000000F0) begin failures++; $display("FAIL flush_val2 got=%h exp=000000f0", val2_1); end
    checks++; if (cout1 !== 1'b0) begin failures++; $display("FAIL flush_cout got=%b exp=0", cout1); end
  endtask

  task automatic test_reset_mid_run();
    issue(32'h80000001, 12'h040, 1'b0, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done1); end
    checks++; if (val2_1 !== 32'd0) begin failures++; $display("FAIL rstmid_val2 got=%h exp=0", val2_1); end
    checks++; if (cout1 !== 1'b0) begin failures++; $display("FAIL rstmid_cout got=%b exp=0", cout1); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_los();
    test_imm();
    test_lsl();
    test_asr();
    test_rrx();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
